// File: rtl/pixel_packer.sv
// Packs one color index per dot clock MSB-first into 16-bit words at 1/2/4/8 bpp
// and buffers completed words in a 2-entry first-word-fall-through FIFO.
module pixel_packer (
   input  logic        dotclk_i,
   input  logic        rst_ni,
   input  logic [1:0]  mode_i,
   input  logic        pix_valid_i,
   input  logic [7:0]  pix_i,
   input  logic [7:0]  index_xor_i,
   input  logic        flush_i,
   output logic        pix_ready_o,
   output logic [15:0] word_o,
   output logic        word_valid_o,
   input  logic        word_ready_i
);

   localparam logic StEmpty   = 1'b0;
   localparam logic StFilling = 1'b1;

   logic [15:0] acc_q, acc_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  mode_q, mode_d;
   logic        state;

   logic [1:0]  eff_mode;
   logic [7:0]  pix_x, pix_m;
   logic [4:0]  pos_end, shamt, cnt_pk;
   logic [15:0] placed, acc_pk;
   logic        accept, flush_ok, last, push, pop;

   logic [15:0] head_q, head_d, tail_q, tail_d;
   logic [1:0]  fcnt_q, fcnt_d;

   assign state       = (cnt_q == 4'd0) ? StEmpty : StFilling;
   assign pix_ready_o = (fcnt_q < 2'd2);
   assign accept      = pix_valid_i & pix_ready_o;
   assign flush_ok    = flush_i & pix_ready_o;

   // The mode is only sampled for the first pixel of a word.
   assign eff_mode = (state == StEmpty) ? mode_i : mode_q;
   assign pix_x    = pix_i ^ index_xor_i;

   always_comb begin
      pix_m = 8'd0;
      case (eff_mode)
         2'd0:    pix_m = {7'd0, pix_x[0]};
         2'd1:    pix_m = {6'd0, pix_x[1:0]};
         2'd2:    pix_m = {4'd0, pix_x[3:0]};
         default: pix_m = pix_x;
      endcase
   end

   // pos_end = bits consumed once this pixel lands; the pixel sits just above 16 - pos_end.
   assign pos_end = ({1'b0, cnt_q} + 5'd1) << eff_mode;
   assign shamt   = 5'd16 - pos_end;
   assign placed  = {8'd0, pix_m} << shamt;
   assign last    = (pos_end == 5'd16);

   assign acc_pk = accept ? (acc_q | placed) : acc_q;
   assign cnt_pk = {1'b0, cnt_q} + {4'd0, accept};
   assign push   = (accept & last) | (flush_ok & (cnt_pk != 5'd0));

   always_comb begin
      acc_d  = push ? 16'd0 : acc_pk;
      cnt_d  = push ? 4'd0 : cnt_pk[3:0];
      mode_d = (accept && state == StEmpty) ? mode_i : mode_q;
   end

   assign word_valid_o = (fcnt_q != 2'd0);
   assign word_o       = word_valid_o ? head_q : 16'd0;
   assign pop          = word_valid_o & word_ready_i;

   // Push never coincides with count 2, so push+pop only happens at count 1.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      fcnt_d = fcnt_q;
      case ({push, pop})
         2'b10: begin
            if (fcnt_q == 2'd0) head_d = acc_pk;
            else                tail_d = acc_pk;
            fcnt_d = fcnt_q + 2'd1;
         end
         2'b01: begin
            head_d = tail_q;
            fcnt_d = fcnt_q - 2'd1;
         end
         2'b11:   head_d = acc_pk;
         default: ;
      endcase
   end

   always_ff @(posedge dotclk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q  <= 16'd0;
         cnt_q  <= 4'd0;
         mode_q <= 2'd0;
         head_q <= 16'd0;
         tail_q <= 16'd0;
         fcnt_q <= 2'd0;
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
         head_q <= head_d;
         tail_q <= tail_d;
         fcnt_q <= fcnt_d;
      end
   end

endmodule
